// File: rtl/ad_symframe.sv
// ADC symbol framer: drops the cyclic prefix and emits 64-sample symbols in two's complement.
// Define AD_SYMFRAME_DCBLOCK_EN to add per-channel DC removal (adds one cycle of latency).
module ad_symframe #(
    parameter int unsigned CP_LEN     = 16,
    parameter bit          OFFSET_BIN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] adc_i,
    input  logic [7:0] adc_q,
    input  logic       adc_strobe,
    input  logic       sym_sync,
    output logic [7:0] ad1,
    output logic [7:0] ad2,
    output logic       ad_valid,
    output logic       ad_sof,
    output logic [7:0] sym_cnt,
    output logic       sync_err
);

    typedef enum logic [1:0] {StIdle, StSkip, StPass} state_e;

    localparam logic [7:0] CodeFlip   = OFFSET_BIN ? 8'h80 : 8'h00;
    localparam logic [5:0] CpLast     = 6'(CP_LEN - 1);
    // With no prefix the symbol boundary lands directly in PASS.
    localparam state_e     StAfterSym = state_e'((CP_LEN == 0) ? StPass : StSkip);

    state_e     state_q, state_d, cur_state;
    logic [5:0] cnt_q, cnt_d, cur_cnt;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic       sync_err_q, sync_err_d;
    logic       emit, sof;

    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        sync_err_d = sync_err_q;
        emit       = 1'b0;
        sof        = 1'b0;
        cur_state  = state_q;
        cur_cnt    = cnt_q;
        if (sym_sync) begin
            if (state_q == StPass) sync_err_d = 1'b1;
            cur_state = StAfterSym;
            cur_cnt   = '0;
        end
        state_d = cur_state;
        cnt_d   = cur_cnt;
        // A strobe coincident with sym_sync is processed in the freshly entered phase.
        if (adc_strobe) begin
            case (cur_state)
                StSkip: begin
                    if (cur_cnt == CpLast) begin
                        state_d = StPass;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cur_cnt + 6'd1;
                    end
                end
                StPass: begin
                    emit = 1'b1;
                    sof  = (cur_cnt == 6'd0);
                    if (cur_cnt == 6'd63) begin
                        state_d   = StAfterSym;
                        cnt_d     = '0;
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end else begin
                        cnt_d = cur_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sym_cnt_q  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    logic [7:0] x_re, x_im;
    logic [7:0] ad1_q, ad2_q;
    logic       valid_q, sof_q;

    assign x_re = adc_i ^ CodeFlip;
    assign x_im = adc_q ^ CodeFlip;

`ifdef AD_SYMFRAME_DCBLOCK_EN
    logic               strb1_q, emit1_q, sof1_q;
    logic [7:0]         x1_re_q, x1_im_q;
    logic signed [15:0] acc_re_q, acc_im_q;
    logic signed [16:0] y_re, y_im;

    function automatic logic [7:0] sat8(input logic signed [16:0] v);
        if (v > 17'sd127) return 8'h7f;
        else if (v < -17'sd128) return 8'h80;
        else return v[7:0];
    endfunction

    // y = x - (acc >>> 6), both sign-extended to 17 bits so the difference cannot wrap.
    assign y_re = $signed({{9{x1_re_q[7]}}, x1_re_q}) - $signed({{7{acc_re_q[15]}}, acc_re_q[15:6]});
    assign y_im = $signed({{9{x1_im_q[7]}}, x1_im_q}) - $signed({{7{acc_im_q[15]}}, acc_im_q[15:6]});

    always_ff @(posedge CLK) begin
        if (RST) begin
            strb1_q  <= 1'b0;
            emit1_q  <= 1'b0;
            sof1_q   <= 1'b0;
            x1_re_q  <= '0;
            x1_im_q  <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            ad1_q    <= '0;
            ad2_q    <= '0;
        end else begin
            strb1_q <= adc_strobe;
            emit1_q <= emit;
            sof1_q  <= sof;
            if (adc_strobe) begin
                x1_re_q <= x_re;
                x1_im_q <= x_im;
            end
            // Accumulators track every strobe, including prefix and idle samples.
            if (strb1_q) begin
                acc_re_q <= acc_re_q + y_re[15:0];
                acc_im_q <= acc_im_q + y_im[15:0];
            end
            valid_q <= emit1_q;
            sof_q   <= sof1_q;
            if (emit1_q) begin
                ad1_q <= sat8(y_re);
                ad2_q <= sat8(y_im);
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            ad1_q   <= '0;
            ad2_q   <= '0;
        end else begin
            valid_q <= emit;
            sof_q   <= sof;
            if (emit) begin
                ad1_q <= x_re;
                ad2_q <= x_im;
            end
        end
    end
`endif

    assign ad1      = ad1_q;
    assign ad2      = ad2_q;
    assign ad_valid = valid_q;
    assign ad_sof   = sof_q;
    assign sym_cnt  = sym_cnt_q;
    assign sync_err = sync_err_q;

endmodule

// File: doc/ad_symframe.md
AD_SYMFRAME -- requirements
Module: ad_symframe

Interface
REQ-001 Parameter CP_LEN, default 16, cyclic-prefix samples discarded before each 64-sample symbol (legal 0..63).
REQ-002 Parameter OFFSET_BIN, default 1, 1 = ADC codes are offset-binary and are converted to two's complement, 0 = codes pass through unchanged.
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 adc_i  in  8  raw I sample from the ADC.
REQ-006 adc_q  in  8  raw Q sample from the ADC.
REQ-007 adc_strobe  in  1  adc_i/adc_q hold a new sample this cycle.
REQ-008 sym_sync  in  1  one-cycle pulse marking the first CP sample of a symbol.
REQ-009 ad1  out  8  I sample, two's complement, to the rescale/FFT path.
REQ-010 ad2  out  8  Q sample, two's complement.
REQ-011 ad_valid  out  1  ad1/ad2 valid; asserted exactly 64 times per symbol.
REQ-012 ad_sof  out  1  high with the first ad_valid of each symbol.
REQ-013 sym_cnt  out  8  symbols delivered since reset, wraps at 255 to 0.
REQ-014 sync_err  out  1  sticky; set when sym_sync arrives while in PASS.

Function
REQ-015 FSM states: IDLE, SKIP, PASS.
REQ-016 IDLE: discard all strobes; sym_sync -> SKIP with sample counter 0.
REQ-017 sym_sync and adc_strobe in the same cycle: that strobe counts as CP sample 0.
REQ-018 SKIP: each strobe increments the counter and produces no output; after CP_LEN strobes -> PASS, counter 0 (CP_LEN=0 -> straight to PASS).
REQ-019 PASS: each strobe emits one output sample and increments the counter; the 64th sample -> SKIP, counter 0, sym_cnt +1.
REQ-020 Back-to-back symbols need no further sym_sync: SKIP/PASS alternate indefinitely.
REQ-021 sym_sync in SKIP restarts SKIP at counter 0; no error.
REQ-022 sym_sync in PASS aborts the partial symbol, sets sync_err, enters SKIP at counter 0, and leaves sym_cnt unchanged; the 64-sample count invariant is therefore broken for that symbol only.
REQ-023 Conversion with OFFSET_BIN=1: output = code XOR 8'h80.
REQ-024 Output latency: ad_valid asserts 1 cycle after the accepting strobe, with DC block compiled out.
REQ-025 ad_valid is a single-cycle pulse per strobe.
REQ-026 ad1/ad2 hold their last value while ad_valid=0.
REQ-027 No backpressure: the downstream FIFO absorbs every sample.

Reset
REQ-028 RST high for one cycle forces: state IDLE, counter 0, ad1=ad2=0, ad_valid=0, ad_sof=0, sym_cnt=0, sync_err=0, DC accumulators 0.
REQ-029 Reset mid-symbol discards the partial symbol.
REQ-030 Reset has priority over sym_sync in the same cycle.

Configuration
REQ-031 Macro AD_SYMFRAME_DCBLOCK_EN.
REQ-032 Defined: per-channel DC removal after conversion.
- acc (16-bit signed) += x - (acc>>>6) on each strobe, in every state.
- output = sat8(x - (acc>>>6)).
- output latency becomes 2 cycles.
REQ-033 Undefined: no accumulator logic, latency 1.

Verification
REQ-034 Reset, then sym_sync with 16+64 strobes of I=8'h85, Q=8'h7B -> 64 ad_valid, ad1=8'h05, ad2=8'hFB, ad_sof on first, sym_cnt=1.
REQ-035 Continuous strobes for 3×80 after one sym_sync -> 192 outputs, ad_sof at output indices 0/64/128, sym_cnt=3, sync_err=0.
REQ-036 sym_sync at PASS sample 30 -> outputs stop after 30, sync_err=1, next 16 strobes dropped, then a full 64, sym_cnt=1.
REQ-037 Strobes every 3rd cycle, CP_LEN=0 -> 64 outputs, each 1 cycle after its strobe (DC block off).
REQ-038 RST at PASS sample 40 -> all outputs 0, IDLE, strobes ignored until next sym_sync.
REQ-039 DC block on, constant input 8'hA0 (OFFSET_BIN=1) for 2000 strobes -> ad1 decays from 8'h20 toward 0, settling within ±1.
